// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (core and debug/loader) with one transaction outstanding.
// Partial-byte stores are turned into a read-modify-write against a combinational memory.
module dmem_arbiter #(
    parameter int NREQ_W = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [31:0]       c_wdata,
    input  logic [3:0]        c_be,
    output logic              c_gnt,
    output logic              c_done,
    output logic [31:0]       c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic [31:0]       m_r_addr,
    output logic [31:0]       m_w_addr,
    output logic [31:0]       m_data_in,
    output logic              m_read,
    output logic              m_write,
    input  logic [31:0]       m_data_out,
    output logic              busy,
    output logic [NREQ_W-1:0] gnt_id
);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_t;

    state_t             state_reg, state_next;
    logic [29:0]        word_reg;
    logic [31:0]        wdata_reg, merged_reg, merged_next;
    logic [31:0]        c_rdata_reg, d_rdata_reg;
    logic [3:0]         be_reg;
    logic               last_reg, done_reg, done_next;
    logic [NREQ_W-1:0]  gnt_id_reg;
    logic               grant, win;
    logic               sel_we;
    logic [31:0]        sel_addr, sel_wdata;
    logic [3:0]         sel_be;
    logic               unused_addr_bits;

    // Byte-aligned low address bits carry no meaning for a word memory.
    assign unused_addr_bits = ^{c_addr[1:0], d_addr[1:0]};

    // Only a tie consults the round-robin pointer; last_reg=1 favours the core.
    always_comb begin
        grant     = reset_n && (state_reg == IDLE) && (c_req || d_req);
        win       = (c_req && d_req) ? ~last_reg : d_req;
        sel_we    = win ? d_we    : c_we;
        sel_addr  = win ? d_addr  : c_addr;
        sel_wdata = win ? d_wdata : c_wdata;
        sel_be    = win ? d_be    : c_be;
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant) begin
                    if (!sel_we)
                        state_next = LOAD;
                    else if (sel_be == 4'hF)
                        state_next = STORE;
                    else if (sel_be != 4'h0)
                        state_next = RMW_RD;
                    else
                        done_next = 1'b1;
                end
            end
            LOAD, STORE, RMW_WR: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            RMW_RD:  state_next = RMW_WR;
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged_next[gi*8 +: 8] = be_reg[gi] ? wdata_reg[gi*8 +: 8]
                                                   : m_data_out[gi*8 +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            word_reg    <= '0;
            wdata_reg   <= '0;
            be_reg      <= '0;
            merged_reg  <= '0;
            c_rdata_reg <= '0;
            d_rdata_reg <= '0;
            last_reg    <= 1'b1;
            done_reg    <= 1'b0;
            gnt_id_reg  <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (grant) begin
                word_reg   <= sel_addr[31:2];
                wdata_reg  <= sel_wdata;
                be_reg     <= sel_be;
                last_reg   <= win;
                gnt_id_reg <= NREQ_W'(win);
            end
            if (state_reg == RMW_RD)
                merged_reg <= merged_next;
            if (state_reg == LOAD) begin
                if (gnt_id_reg == '0)
                    c_rdata_reg <= m_data_out;
                else
                    d_rdata_reg <= m_data_out;
            end
        end
    end

    assign c_gnt     = grant && !win;
    assign d_gnt     = grant && win;
    assign c_done    = done_reg && (gnt_id_reg == '0);
    assign d_done    = done_reg && (gnt_id_reg != '0);
    assign c_rdata   = c_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign m_r_addr  = {2'b00, word_reg};
    assign m_w_addr  = {2'b00, word_reg};
    assign m_data_in = (state_reg == RMW_WR) ? merged_reg : wdata_reg;
    assign m_read    = (state_reg == LOAD)  || (state_reg == RMW_RD);
    assign m_write   = (state_reg == STORE) || (state_reg == RMW_WR);
    assign busy      = (state_reg != IDLE);
    assign gnt_id    = gnt_id_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: loads, full/partial/empty stores, round-robin, mid-RMW reset.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [3:0]  c_be, d_be;
    logic        c_gnt, c_done, d_gnt, d_done;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] m_r_addr, m_w_addr, m_data_in, m_data_out;
    logic        m_read, m_write, busy;
    logic [0:0]  gnt_id;

    logic [31:0] mem [0:15];
    int          checks = 0;
    int          errors = 0;
    int          write_count = 0;
    int          saved_writes;

    always #5 clk = ~clk;

    dmem_arbiter #(.NREQ_W(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_r_addr(m_r_addr), .m_w_addr(m_w_addr), .m_data_in(m_data_in),
        .m_read(m_read), .m_write(m_write), .m_data_out(m_data_out),
        .busy(busy), .gnt_id(gnt_id)
    );

    // Combinational-read memory model with synchronous write.
    assign m_data_out = mem[m_r_addr[3:0]];

    always @(posedge clk) begin
        if (m_write) begin
            mem[m_w_addr[3:0]] <= m_data_in;
            write_count <= write_count + 1;
        end
    end

    // Protocol invariants sampled on every falling edge.
    always @(negedge clk) begin
        checks++;
        assert (!(m_read && m_write)) else begin
            errors++;
            $error("FAIL rw_exclusive observed m_read=%b m_write=%b expected not both", m_read, m_write);
        end
        checks++;
        assert (!(busy && (c_gnt || d_gnt))) else begin
            errors++;
            $error("FAIL gnt_while_busy observed c_gnt=%b d_gnt=%b expected 0 while busy", c_gnt, d_gnt);
        end
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check1 ({tag, "_c_gnt"},  c_gnt,  1'b0);
        check1 ({tag, "_d_gnt"},  d_gnt,  1'b0);
        check1 ({tag, "_c_done"}, c_done, 1'b0);
        check1 ({tag, "_d_done"}, d_done, 1'b0);
        check32({tag, "_c_rdata"}, c_rdata, 32'h0);
        check32({tag, "_d_rdata"}, d_rdata, 32'h0);
        check32({tag, "_m_r_addr"}, m_r_addr, 32'h0);
        check32({tag, "_m_w_addr"}, m_w_addr, 32'h0);
        check32({tag, "_m_data_in"}, m_data_in, 32'h0);
        check1 ({tag, "_m_read"},  m_read,  1'b0);
        check1 ({tag, "_m_write"}, m_write, 1'b0);
        check1 ({tag, "_busy"},    busy,    1'b0);
        check1 ({tag, "_gnt_id"},  gnt_id[0], 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0101_0101 * i;
        mem[4] = 32'hDEAD_BEEF;
        mem[5] = 32'hAABB_CCDD;
        reset_n = 1'b0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Core load of word 4.
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 32'h10; c_be = 4'hF;
        #1;
        check1("load_c_gnt", c_gnt, 1'b1);
        check1("load_d_gnt", d_gnt, 1'b0);
        check1("load_idle",  busy,  1'b0);
        @(negedge clk); c_req = 0; #1;
        check1 ("load_m_read", m_read, 1'b1);
        check32("load_m_r_addr", m_r_addr, 32'd4);
        check1 ("load_busy", busy, 1'b1);
        check1 ("load_gnt_id", gnt_id[0], 1'b0);
        check1 ("load_no_early_done", c_done, 1'b0);
        step();
        check1 ("load_c_done", c_done, 1'b1);
        check1 ("load_d_done", d_done, 1'b0);
        check32("load_c_rdata", c_rdata, 32'hDEAD_BEEF);
        check1 ("load_back_idle", busy, 1'b0);
        $display("txn core load addr=0x10 rdata=%h", c_rdata);
        step();
        check1 ("load_done_pulse", c_done, 1'b0);

        // Debug partial store be=0110 into word 5.
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h14; d_wdata = 32'h1122_3344; d_be = 4'b0110;
        #1;
        check1("rmw_d_gnt", d_gnt, 1'b1);
        check1("rmw_c_gnt", c_gnt, 1'b0);
        @(negedge clk); d_req = 0; #1;
        check1 ("rmw_rd_read", m_read, 1'b1);
        check1 ("rmw_rd_nowrite", m_write, 1'b0);
        check32("rmw_rd_addr", m_r_addr, 32'd5);
        check1 ("rmw_gnt_id", gnt_id[0], 1'b1);
        step();
        check1 ("rmw_wr_write", m_write, 1'b1);
        check1 ("rmw_wr_noread", m_read, 1'b0);
        check32("rmw_wr_addr", m_w_addr, 32'd5);
        check32("rmw_wr_data", m_data_in, 32'hAA22_33DD);
        check1 ("rmw_no_early_done", d_done, 1'b0);
        step();
        check1 ("rmw_d_done", d_done, 1'b1);
        check1 ("rmw_c_done", c_done, 1'b0);
        check32("rmw_mem", mem[5], 32'hAA22_33DD);
        $display("txn debug rmw addr=0x14 be=0110 mem=%h", mem[5]);

        // Core full store into word 8.
        @(negedge clk);
        c_req = 1; c_we = 1; c_addr = 32'h20; c_wdata = 32'h1234_5678; c_be = 4'hF;
        #1;
        check1("st_c_gnt", c_gnt, 1'b1);
        @(negedge clk); c_req = 0; #1;
        check1 ("st_write", m_write, 1'b1);
        check32("st_w_addr", m_w_addr, 32'd8);
        check32("st_data", m_data_in, 32'h1234_5678);
        step();
        check1 ("st_c_done", c_done, 1'b1);
        check32("st_mem", mem[8], 32'h1234_5678);
        check32("st_c_rdata_held", c_rdata, 32'hDEAD_BEEF);
        check32("st_d_rdata_zero", d_rdata, 32'h0);
        $display("txn core store addr=0x20 mem=%h", mem[8]);

        // Core store with be=0: no memory access, done next cycle.
        saved_writes = write_count;
        @(negedge clk);
        c_req = 1; c_we = 1; c_addr = 32'h24; c_wdata = 32'hFFFF_FFFF; c_be = 4'h0;
        #1;
        check1("be0_c_gnt", c_gnt, 1'b1);
        @(negedge clk); c_req = 0; #1;
        check1 ("be0_c_done", c_done, 1'b1);
        check1 ("be0_busy", busy, 1'b0);
        check1 ("be0_no_write", m_write, 1'b0);
        step();
        check32("be0_write_count", 32'(write_count), 32'(saved_writes));
        check32("be0_mem", mem[9], 32'h0909_0909);
        $display("txn core store be=0 writes=%0d", write_count - saved_writes);

        // Continuous loads from both: last grant was core, so debug wins first.
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 32'h10; c_be = 4'hF;
        d_req = 1; d_we = 0; d_addr = 32'h14; d_be = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                check1("rr_c_gnt", c_gnt, ((k / 2) % 2) == 1);
                check1("rr_d_gnt", d_gnt, ((k / 2) % 2) == 0);
                if (k >= 2) begin
                    check1("rr_c_done", c_done, ((k / 2) % 2) == 0);
                    check1("rr_d_done", d_done, ((k / 2) % 2) == 1);
                end
                $display("txn rr slot=%0d c_gnt=%b d_gnt=%b", k / 2, c_gnt, d_gnt);
            end else begin
                check1("rr_idle_c_gnt", c_gnt, 1'b0);
                check1("rr_idle_d_gnt", d_gnt, 1'b0);
            end
            step();
        end
        c_req = 0; d_req = 0;
        #0;
        check1 ("rr_last_c_done", c_done, 1'b1);
        check32("rr_c_rdata", c_rdata, 32'hDEAD_BEEF);
        check32("rr_d_rdata", d_rdata, 32'hAA22_33DD);

        // Reset in the middle of a partial store to word 6.
        saved_writes = write_count;
        @(negedge clk);
        c_req = 1; c_we = 1; c_addr = 32'h18; c_wdata = 32'h0000_00FF; c_be = 4'h1;
        #1;
        check1("rst_c_gnt", c_gnt, 1'b1);
        @(negedge clk); c_req = 0; #1;
        check1("rst_in_rmw_rd", m_read, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check1("rst_no_c_done", c_done, 1'b0);
        step();
        check1 ("rst_no_c_done2", c_done, 1'b0);
        check32("rst_mem_unchanged", mem[6], 32'h0606_0606);
        check32("rst_no_write", 32'(write_count), 32'(saved_writes));
        $display("txn reset during rmw mem=%h", mem[6]);

        // First tie after reset goes to the core.
        @(negedge clk);
        c_req = 1; c_we = 0; c_addr = 32'h10; c_be = 4'hF;
        d_req = 1; d_we = 0; d_addr = 32'h14; d_be = 4'hF;
        #1;
        check1("tie_c_gnt", c_gnt, 1'b1);
        check1("tie_d_gnt", d_gnt, 1'b0);
        @(negedge clk); c_req = 0; d_req = 0; #1;
        step();
        check1 ("tie_c_done", c_done, 1'b1);
        check32("tie_c_rdata", c_rdata, 32'hDEAD_BEEF);
        $display("txn tie after reset c_rdata=%h", c_rdata);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: NREQ_W, default 1, width of the grant-index output (2 requesters).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 c_req, c_we  input  1 each  core request, 1=store / 0=load.
REQ-005 c_addr, c_wdata  input  32 each  core byte address, store data.
REQ-006 c_be  input  4  core byte enables (bit i = byte lane i).
REQ-007 c_gnt, c_done  output  1 each  core request accepted, transaction complete (1-cycle pulses).
REQ-008 c_rdata  output  32  core load data, valid only while c_done is high on a load.
REQ-009 d_req, d_we, d_addr, d_wdata, d_be, d_gnt, d_done, d_rdata: same widths and meanings for the debug/loader requester.
REQ-010 m_r_addr, m_w_addr  output  32 each  memory word index.
REQ-011 m_data_in  output  32  memory write data.
REQ-012 m_read, m_write  output  1 each  memory read/write strobes.
REQ-013 m_data_out  input  32  combinational memory read data.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 gnt_id  output  NREQ_W  index of the requester owning the current transaction (0=core, 1=debug).

Function
REQ-016 FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR; exactly one transaction outstanding.
REQ-017 In IDLE, requests are sampled; the *_gnt of the winner asserts combinationally in that cycle, and op, addr, wdata and be are latched at the clock edge.
REQ-018 Arbitration: only one request pending -> it wins; both pending -> the requester not granted last wins (round-robin); last-grant register resets to 1, so the core wins the first tie.
REQ-019 Requests are ignored and *_gnt stays low while busy; a requester holds *_req until *_gnt and may drop it afterwards.
REQ-020 Transitions out of IDLE: load -> LOAD; store with be=4'hF -> STORE; store with be in 4'h1..4'hE -> RMW_RD; store with be=4'h0 -> IDLE, with *_done pulsing the next cycle and no memory access.
REQ-021 Address mapping: m_r_addr = m_w_addr = {2'b00, addr[31:2]}; addr[1:0] are ignored (word-aligned only).
REQ-022 LOAD (1 cycle): m_read=1; m_data_out is registered into *_rdata; next state IDLE; *_done pulses in the following cycle.
REQ-023 STORE (1 cycle): m_write=1, m_data_in=wdata; next state IDLE; *_done pulses in the following cycle.
REQ-024 RMW_RD (1 cycle): m_read=1; merged word registered, with byte lane i = wdata lane i if be[i] else m_data_out lane i.
REQ-025 RMW_WR (1 cycle): m_write=1, m_data_in=merged word; next state IDLE; *_done pulses in the following cycle.
REQ-026 m_read and m_write are never high in the same cycle; both are 0 in IDLE.
REQ-027 Latency from the grant cycle N: load or full store -> done at N+2; partial store -> done at N+3.
REQ-028 A new grant may occur in the same cycle as the previous *_done pulse (back-to-back throughput).
REQ-029 *_rdata holds its last load value until the next load for that requester completes; it is 0 after reset.
REQ-030 Only the owning requester's *_done pulses; gnt_id is stable from the grant edge until return to IDLE.

Reset
REQ-031 On reset_n low, immediately: state=IDLE; last-grant=1; all outputs 0 (gnt, done, rdata, m_* strobes, addresses, data, busy, gnt_id).
REQ-032 Reset asserted mid-transaction abandons it: no m_write occurs after the reset edge and no *_done is issued.

Verification
REQ-033 Core load, addr 0x0000_0010, memory word 4 = 0xDEADBEEF -> c_gnt in cycle N, m_read with m_r_addr=4 in N+1, c_done with c_rdata=0xDEADBEEF at N+2.
REQ-034 Debug store, be=4'b0110, wdata=0x11223344, memory word holds 0xAABBCCDD -> sequence RMW_RD then RMW_WR writing 0xAA2233DD; d_done at N+3.
REQ-035 Both requesters request continuously with loads -> grants alternate core, debug, core, ...; no grant while busy; m_read and m_write never both high.
REQ-036 Store with be=0 -> no m_write asserted; c_done at N+1 after the grant.
REQ-037 reset_n pulsed low during RMW_RD -> all outputs 0 asynchronously; the memory word is unchanged; the next tie is won by the core.
